// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter; grant -> Din_valid in 2 edges, byte held until rd_EN.
// Bursts up to MAX_BURST bytes per grant before priority rotates past the granted requester.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ack,
  output logic                       Din_valid,
  output logic [DATA_W-1:0]          data_in,
  input  logic                       rd_EN,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  burst_cnt;

  logic [ID_W-1:0]   arb_g;
  logic [ID_W:0]     idx_sum;
  logic [DATA_W-1:0] sel_data;
  logic [CNT_W-1:0]  burst_nxt;
  logic              burst_cont;
  logic [ID_W-1:0]   ptr_nxt;

  // First requesting index at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    arb_g   = rr_ptr;
    idx_sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx_sum >= (ID_W+1)'(N_REQ)) begin
        idx_sum = idx_sum - (ID_W+1)'(N_REQ);
      end
      if (req[idx_sum[ID_W-1:0]]) begin
        arb_g = idx_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign burst_nxt  = burst_cnt + CNT_W'(1);
  assign burst_cont = req[grant_id] && (burst_nxt < CNT_W'(MAX_BURST));
  assign ptr_nxt    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      req_ack   <= '0;
      Din_valid <= 1'b0;
      data_in   <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id  <= arb_g;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          data_in   <= sel_data;
          Din_valid <= 1'b1;
          req_ack   <= N_REQ'(1) << grant_id;
          state     <= WAIT;
        end
        WAIT: begin
          // req[g] is only looked at on the edge the transmitter takes the byte.
          if (rd_EN) begin
            Din_valid <= 1'b0;
            burst_cnt <= burst_nxt;
            if (burst_cont) begin
              state <= LOAD;
            end else begin
              rr_ptr <= ptr_nxt;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
